// File: rtl/aes_key_schedule_store_if.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_store_if
// Bundles the key-load handshake, status flags and round-key read port of
// aes_key_schedule_store.
//   master : upstream/consumer side (drives key_in, key_valid, rd_en, rd_round)
//   slave  : key schedule block (drives key_ready, busy, sched_valid,
//            rd_key, rd_valid)
// ---------------------------------------------------------------------------
interface aes_key_schedule_store_if #(
    parameter int unsigned KEY_LENGTH = 128
);
    logic [KEY_LENGTH-1:0] key_in;
    logic                  key_valid;
    logic                  key_ready;
    logic                  busy;
    logic                  sched_valid;
    logic                  rd_en;
    logic [3:0]            rd_round;
    logic [KEY_LENGTH-1:0] rd_key;
    logic                  rd_valid;

    modport master (
        output key_in, key_valid, rd_en, rd_round,
        input  key_ready, busy, sched_valid, rd_key, rd_valid
    );

    modport slave (
        input  key_in, key_valid, rd_en, rd_round,
        output key_ready, busy, sched_valid, rd_key, rd_valid
    );
endinterface

// File: rtl/aes_key_schedule_store.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_store
// Sequential AES-128 key expansion (one round per clock) into an 11-entry
// round-key register file, with a registered random-access read port.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   zeroize  : (KEYSCHED_ZEROIZE_EN only) clear all slots, force IDLE
//   bus      : aes_key_schedule_store_if.slave
//              key_in/key_valid/key_ready  key load handshake
//              busy/sched_valid            status
//              rd_en/rd_round -> rd_key/rd_valid, one-cycle read latency
//
// Optional feature macro: KEYSCHED_ZEROIZE_EN
//   Defined   : rst clears slots and work register, a new key clears slots
//               1..10 on its accept edge, and the zeroize port is present.
//   Undefined : slots have no reset; stale contents persist.
// ---------------------------------------------------------------------------
module aes_key_schedule_store #(
    parameter int unsigned KEY_LENGTH = 128,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic clk,
    input  logic rst,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_store_if.slave bus
);

    localparam int unsigned NUM_SLOTS = NUM_ROUNDS + 1;
    localparam logic [3:0]  LAST_RND  = 4'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StReady
    } state_e;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One full AES-128 expansion round: four new words from the previous four.
    function automatic logic [127:0] round_fn(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
        n0 = w[127:96] ^ t;
        n1 = w[95:64]  ^ n0;
        n2 = w[63:32]  ^ n1;
        n3 = w[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [KEY_LENGTH-1:0] work_q, work_d;
    logic [KEY_LENGTH-1:0] slot_q [NUM_SLOTS];
    logic [KEY_LENGTH-1:0] next_key;
    logic                  wr_en;
    logic [3:0]            wr_idx;
    logic [KEY_LENGTH-1:0] wr_data;
    logic                  clr_all;
    logic                  clr_stale;
    logic [KEY_LENGTH-1:0] rd_key_q;
    logic                  rd_valid_q;
    logic [KEY_LENGTH-1:0] rd_data;

    assign next_key = round_fn(work_q, rcon(cnt_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        wr_en     = 1'b0;
        wr_idx    = cnt_q;
        wr_data   = next_key;
        clr_all   = 1'b0;
        clr_stale = 1'b0;
        case (state_q)
            StIdle, StReady: begin
                if (bus.key_valid) begin
                    state_d   = StExpand;
                    cnt_d     = 4'd1;
                    work_d    = bus.key_in;
                    wr_en     = 1'b1;
                    wr_idx    = 4'd0;
                    wr_data   = bus.key_in;
                    clr_stale = 1'b1;
                end
            end
            StExpand: begin
                wr_en  = 1'b1;
                work_d = next_key;
                if (cnt_q >= LAST_RND) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef KEYSCHED_ZEROIZE_EN
        // Zeroize outranks key acceptance and any expansion in flight.
        if (zeroize) begin
            state_d   = StIdle;
            cnt_d     = 4'd0;
            work_d    = '0;
            wr_en     = 1'b0;
            clr_stale = 1'b0;
            clr_all   = 1'b1;
        end
`endif
    end

    // Out-of-range indices read as zero but still report valid.
    assign rd_data = (bus.rd_round <= LAST_RND) ? slot_q[bus.rd_round] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_key_q <= rd_data;
            end
        end
    end

`ifdef KEYSCHED_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            work_q <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            work_q <= work_d;
            if (clr_stale) begin
                for (int i = 1; i < int'(NUM_SLOTS); i++) begin
                    slot_q[i] <= '0;
                end
            end
            if (wr_en) begin
                slot_q[wr_idx] <= wr_data;
            end
        end
    end
`else
    // Key material is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            work_q <= work_d;
            if (wr_en) begin
                slot_q[wr_idx] <= wr_data;
            end
        end
    end
    logic unused_clr;
    assign unused_clr = clr_all | clr_stale;
`endif

    assign bus.key_ready   = (state_q != StExpand);
    assign bus.busy        = (state_q == StExpand);
    assign bus.sched_valid = (state_q == StReady);
    assign bus.rd_key      = rd_key_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_store.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_store
// Self-checking bench for aes_key_schedule_store. The reference is the
// textbook word-by-word AES-128 key expansion, with its S-box derived from
// GF(2^8) inversion plus the affine map.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_store;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef KEYSCHED_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    aes_key_schedule_store_if bus ();

    aes_key_schedule_store dut (
        .clk     (clk),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_keys [11];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]], sbox_m[temp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] key);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_sched(output int n);
        n = 0;
        while (!bus.sched_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic read_slot(input logic [3:0] r, output logic [127:0] k, output logic v);
        bus.rd_en    = 1'b1;
        bus.rd_round = r;
        tick();
        k = bus.rd_key;
        v = bus.rd_valid;
        bus.rd_en = 1'b0;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 5;
        if (bus.key_ready !== 1'b1) begin
            errors++; $display("FAIL reset key_ready got %b want 1", bus.key_ready);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset busy got %b want 0", bus.busy);
        end
        if (bus.sched_valid !== 1'b0) begin
            errors++; $display("FAIL reset sched_valid got %b want 0", bus.sched_valid);
        end
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset rd_valid got %b want 0", bus.rd_valid);
        end
        if (bus.rd_key !== 128'h0) begin
            errors++; $display("FAIL reset rd_key got %h want 0", bus.rd_key);
        end
    endtask

    task automatic test_fips_vector();
        logic [127:0] k;
        logic         v;
        logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(key);
        accept(key);
        // Sampled after the accept edge and each of the ten expansion edges.
        for (int i = 0; i <= 10; i++) begin
            checks += 3;
            if (bus.busy !== (i < 10)) begin
                errors++; $display("FAIL fips busy edge %0d got %b", i, bus.busy);
            end
            if (bus.sched_valid !== (i == 10)) begin
                errors++; $display("FAIL fips sched_valid edge %0d got %b", i, bus.sched_valid);
            end
            if (bus.key_ready !== (i == 10)) begin
                errors++; $display("FAIL fips key_ready edge %0d got %b", i, bus.key_ready);
            end
            if (i < 10) tick();
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== exp_keys[r] || v !== 1'b1) begin
                errors++; $display("FAIL fips round %0d got %h/%b want %h/1", r, k, v, exp_keys[r]);
            end
        end
        read_slot(4'd1, k, v);
        checks++;
        if (k !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL fips_r1 got %h want a0fafe17...", k);
        end
        read_slot(4'd10, k, v);
        checks++;
        if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL fips_r10 got %h want d014f9a8...", k);
        end
    endtask

    task automatic test_zero_key();
        logic [127:0] k;
        logic         v;
        int           n;
        model_expand(128'h0);
        accept(128'h0);
        wait_sched(n);
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL zero_key latency got %0d want 10", n);
        end
        read_slot(4'd1, k, v);
        checks++;
        if (k !== 128'h62636363626363636263636362636363) begin
            errors++; $display("FAIL zero_key_r1 got %h want 62636363...", k);
        end
        read_slot(4'd10, k, v);
        checks++;
        if (k !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++; $display("FAIL zero_key_r10 got %h want b4ef5bcb...", k);
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== exp_keys[r]) begin
                errors++; $display("FAIL zero_key round %0d got %h want %h", r, k, exp_keys[r]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] ka = rand_key();
        logic [127:0] kb = rand_key();
        logic [127:0] k;
        logic         v;
        int           n;
        model_expand(ka);
        accept(ka);
        bus.key_in    = kb;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.key_ready !== 1'b0) begin
                errors++; $display("FAIL ignore key_ready edge %0d got %b want 0", i, bus.key_ready);
            end
            tick();
        end
        bus.key_valid = 1'b0;
        checks++;
        if (bus.sched_valid !== 1'b1) begin
            errors++; $display("FAIL ignore sched_valid got %b want 1", bus.sched_valid);
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== exp_keys[r]) begin
                errors++; $display("FAIL ignore first round %0d got %h want %h", r, k, exp_keys[r]);
            end
        end
        model_expand(kb);
        accept(kb);
        checks++;
        if (bus.sched_valid !== 1'b0) begin
            errors++; $display("FAIL rekey sched_valid got %b want 0", bus.sched_valid);
        end
        wait_sched(n);
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL rekey latency got %0d want 10", n);
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== exp_keys[r]) begin
                errors++; $display("FAIL rekey round %0d got %h want %h", r, k, exp_keys[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        logic         v;
        int           n;
        logic [127:0] key = rand_key();
        accept(rand_key());
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (bus.key_ready !== 1'b1) begin
            errors++; $display("FAIL midrst key_ready got %b want 1", bus.key_ready);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL midrst busy got %b want 0", bus.busy);
        end
        if (bus.sched_valid !== 1'b0) begin
            errors++; $display("FAIL midrst sched_valid got %b want 0", bus.sched_valid);
        end
        model_expand(key);
        accept(key);
        wait_sched(n);
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL midrst latency got %0d want 10", n);
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== exp_keys[r]) begin
                errors++; $display("FAIL midrst round %0d got %h want %h", r, k, exp_keys[r]);
            end
        end
    endtask

    task automatic test_read_sweep();
        logic [127:0] want;
        bus.rd_en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            bus.rd_round = 4'(r);
            tick();
            want = (r <= 10) ? exp_keys[r] : 128'h0;
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_key !== want) begin
                errors++;
                $display("FAIL sweep idx %0d got %h/%b want %h/1", r, bus.rd_key, bus.rd_valid, want);
            end
        end
        bus.rd_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL sweep idle rd_valid got %b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_collision();
        logic [127:0] k1 = rand_key();
        logic [127:0] k2 = rand_key();
        logic [127:0] old_r1;
        logic [127:0] stale;
        logic [127:0] k;
        logic         v;
        int           n;
        model_expand(k1);
        accept(k1);
        wait_sched(n);
        old_r1 = exp_keys[1];
        model_expand(k2);
        // Read slot 1 on the accept edge, then on the edge that rewrites it.
        bus.rd_en     = 1'b1;
        bus.rd_round  = 4'd1;
        bus.key_in    = k2;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if (bus.rd_key !== old_r1) begin
            errors++; $display("FAIL collide accept got %h want %h", bus.rd_key, old_r1);
        end
        tick();
        bus.rd_en = 1'b0;
`ifdef KEYSCHED_ZEROIZE_EN
        stale = 128'h0;
`else
        stale = old_r1;
`endif
        checks++;
        if (bus.rd_key !== stale) begin
            errors++; $display("FAIL collide write got %h want %h", bus.rd_key, stale);
        end
        wait_sched(n);
        read_slot(4'd1, k, v);
        checks++;
        if (k !== exp_keys[1]) begin
            errors++; $display("FAIL collide new r1 got %h want %h", k, exp_keys[1]);
        end
    endtask

    task automatic test_random_keys();
        logic [127:0] key;
        logic [127:0] k;
        logic         v;
        int           n;
        for (int t = 0; t < 4; t++) begin
            key = rand_key();
            model_expand(key);
            accept(key);
            wait_sched(n);
            checks++;
            if (n != 10) begin
                errors++; $display("FAIL random %0d latency got %0d want 10", t, n);
            end
            for (int r = 0; r < 11; r++) begin
                read_slot(4'(r), k, v);
                checks++;
                if (k !== exp_keys[r]) begin
                    errors++; $display("FAIL random %0d round %0d got %h want %h", t, r, k, exp_keys[r]);
                end
            end
        end
    endtask

`ifdef KEYSCHED_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] k;
        logic         v;
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checks += 2;
        if (bus.sched_valid !== 1'b0) begin
            errors++; $display("FAIL zeroize sched_valid got %b want 0", bus.sched_valid);
        end
        if (bus.key_ready !== 1'b1) begin
            errors++; $display("FAIL zeroize key_ready got %b want 1", bus.key_ready);
        end
        for (int r = 0; r < 11; r++) begin
            read_slot(4'(r), k, v);
            checks++;
            if (k !== 128'h0) begin
                errors++; $display("FAIL zeroize round %0d got %h want 0", r, k);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_round  = 4'd0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_read_sweep();
        test_zero_key();
        test_busy_ignore();
        test_reset_mid();
        test_collision();
        test_random_keys();
`ifdef KEYSCHED_ZEROIZE_EN
        test_zeroize();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
